// File: rtl/reg7_arb.sv
// Two-requester round-robin write arbiter driving a 7-bit register's data and load enable.
// Optional clear path (CLR state, eclr/sclr) is built when REG7_ARB_CLR_EN is defined.
module reg7_arb (
   input  logic       eck,
   input  logic       ers,
   input  logic       ereq_a,
   input  logic [6:0] ed_a,
   input  logic       ereq_b,
   input  logic [6:0] ed_b,
`ifdef REG7_ARB_CLR_EN
   input  logic       eclr,
   output logic       sclr,
`endif
   output logic [6:0] sd,
   output logic       sena,
   output logic       sack_a,
   output logic       sack_b,
   output logic       sbusy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ACK  = 2'd2
`ifdef REG7_ARB_CLR_EN
      , CLR = 2'd3
`endif
   } state_t;

   state_t r_state;
   logic   r_ptr;      // 0 = A next on contention, 1 = B
   logic   r_grant_b;  // requester owning the current transfer
   logic   w_pick_b;

   always_comb begin
      w_pick_b = (ereq_a && ereq_b) ? r_ptr : ereq_b;
   end

   always_ff @(posedge eck) begin
      if (ers) begin
         r_state   <= IDLE;
         r_ptr     <= 1'b0;
         r_grant_b <= 1'b0;
         sd        <= 7'd0;
         sena      <= 1'b0;
         sack_a    <= 1'b0;
         sack_b    <= 1'b0;
         sbusy     <= 1'b0;
`ifdef REG7_ARB_CLR_EN
         sclr      <= 1'b0;
`endif
      end else begin
         // NOTE: pulse outputs default low each edge so every strobe lasts exactly one cycle.
         sena   <= 1'b0;
         sack_a <= 1'b0;
         sack_b <= 1'b0;
`ifdef REG7_ARB_CLR_EN
         sclr   <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
`ifdef REG7_ARB_CLR_EN
               if (eclr) begin
                  r_state <= CLR;
                  sclr    <= 1'b1;
                  sbusy   <= 1'b1;
               end else
`endif
               if (ereq_a || ereq_b) begin
                  r_state   <= LOAD;
                  r_grant_b <= w_pick_b;
                  sd        <= w_pick_b ? ed_b : ed_a;
                  sena      <= 1'b1;
                  sbusy     <= 1'b1;
               end
            end
            LOAD: begin
               r_state <= ACK;
               sack_a  <= ~r_grant_b;
               sack_b  <= r_grant_b;
               r_ptr   <= ~r_grant_b;
            end
            ACK: begin
               r_state <= IDLE;
               sbusy   <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               sbusy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg7_arb.sv
// Directed self-checking bench for reg7_arb; outputs are packed as {sbusy,sena,sack_a,sack_b,sd}.
// Clear-path scenario is compiled only when REG7_ARB_CLR_EN is defined.
module tb_reg7_arb;

   logic       eck = 1'b0;
   logic       ers = 1'b1;
   logic       ereq_a = 1'b0;
   logic [6:0] ed_a = 7'd0;
   logic       ereq_b = 1'b0;
   logic [6:0] ed_b = 7'd0;
   logic [6:0] sd;
   logic       sena, sack_a, sack_b, sbusy;
`ifdef REG7_ARB_CLR_EN
   logic       eclr = 1'b0;
   logic       sclr;
`endif

   int n_err = 0;
   int n_chk = 0;

   reg7_arb dut (
      .eck    (eck),
      .ers    (ers),
      .ereq_a (ereq_a),
      .ed_a   (ed_a),
      .ereq_b (ereq_b),
      .ed_b   (ed_b),
`ifdef REG7_ARB_CLR_EN
      .eclr   (eclr),
      .sclr   (sclr),
`endif
      .sd     (sd),
      .sena   (sena),
      .sack_a (sack_a),
      .sack_b (sack_b),
      .sbusy  (sbusy)
   );

   always #5 eck = ~eck;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one rising edge and land on the following falling edge for sampling/driving.
   task automatic tick();
      @(posedge eck);
      @(negedge eck);
   endtask

   task automatic do_reset();
      ers    = 1'b1;
      ereq_a = 1'b0;
      ereq_b = 1'b0;
      tick();
      ers = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] got;
      ers    = 1'b1;
      ereq_a = 1'b1;
      ereq_b = 1'b1;
      ed_a   = 7'h7F;
      ed_b   = 7'h7E;
      for (int i = 0; i < 2; i++) begin
         tick();
         got = {sbusy, sena, sack_a, sack_b, sd};
         n_chk++;
         if (got !== 11'h000) begin
            n_err++;
            $display("FAIL reset_hold[%0d]: got %b want %b", i, got, 11'h000);
         end
      end
      ereq_a = 1'b0;
      ereq_b = 1'b0;
      ers    = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         got = {sbusy, sena, sack_a, sack_b, sd};
         n_chk++;
         if (got !== 11'h000) begin
            n_err++;
            $display("FAIL idle_no_req[%0d]: got %b want %b", i, got, 11'h000);
         end
      end
   endtask

   task automatic test_single_a();
      logic [10:0] got;
      logic [10:0] exp [3];
      exp[0] = {4'b1100, 7'h55};
      exp[1] = {4'b1010, 7'h55};
      exp[2] = {4'b0000, 7'h55};
      do_reset();
      ereq_a = 1'b1;
      ed_a   = 7'h55;
      for (int i = 0; i < 3; i++) begin
         tick();
         got = {sbusy, sena, sack_a, sack_b, sd};
         n_chk++;
         if (got !== exp[i]) begin
            n_err++;
            $display("FAIL single_a[%0d]: got %b want %b", i, got, exp[i]);
         end
         if (sack_a) ereq_a = 1'b0;
      end
   endtask

   task automatic test_dual_rr();
      logic [10:0] got, want;
      int ph, g;
      do_reset();
      ereq_a = 1'b1;
      ereq_b = 1'b1;
      ed_a   = 7'h11;
      ed_b   = 7'h22;
      for (int k = 1; k <= 12; k++) begin
         tick();
         ph   = (k - 1) % 3;
         g    = ((k - 1) / 3) % 2;
         want = {ph != 2, ph == 0, (ph == 1) && (g == 0), (ph == 1) && (g == 1),
                 (g == 1) ? 7'h22 : 7'h11};
         got  = {sbusy, sena, sack_a, sack_b, sd};
         n_chk++;
         if (got !== want) begin
            n_err++;
            $display("FAIL dual_rr[%0d]: got %b want %b", k, got, want);
         end
      end
      ereq_a = 1'b0;
      ereq_b = 1'b0;
   endtask

   task automatic test_data_hold();
      logic [10:0] got, want;
      do_reset();
      ereq_b = 1'b1;
      ed_b   = 7'h0F;
      tick();
      ed_b = 7'h70;
      #1;
      want = {4'b1100, 7'h0F};
      got  = {sbusy, sena, sack_a, sack_b, sd};
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL hold_load: got %b want %b", got, want);
      end
      tick();
      want = {4'b1001, 7'h0F};
      got  = {sbusy, sena, sack_a, sack_b, sd};
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL hold_ack: got %b want %b", got, want);
      end
      ereq_b = 1'b0;
      tick();
      want = {4'b0000, 7'h0F};
      got  = {sbusy, sena, sack_a, sack_b, sd};
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL hold_idle: got %b want %b", got, want);
      end
   endtask

   task automatic test_drop_after_grant();
      logic [10:0] got, want;
      do_reset();
      ereq_a = 1'b1;
      ed_a   = 7'h5A;
      tick();
      ereq_a = 1'b0;
      tick();
      want = {4'b1010, 7'h5A};
      got  = {sbusy, sena, sack_a, sack_b, sd};
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL drop_ack: got %b want %b", got, want);
      end
      tick();
      tick();
      want = {4'b0000, 7'h5A};
      got  = {sbusy, sena, sack_a, sack_b, sd};
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL drop_idle: got %b want %b", got, want);
      end
   endtask

   task automatic test_reset_mid();
      logic [10:0] got, want;
      do_reset();
      // Finish one A transfer so the pointer favours B before the aborted one.
      ereq_a = 1'b1;
      ed_a   = 7'h33;
      tick();
      tick();
      ereq_a = 1'b0;
      tick();
      ereq_a = 1'b1;
      ed_a   = 7'h44;
      tick();
      want = {4'b1100, 7'h44};
      got  = {sbusy, sena, sack_a, sack_b, sd};
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL rst_mid_load: got %b want %b", got, want);
      end
      ers = 1'b1;
      tick();
      ers = 1'b0;
      got = {sbusy, sena, sack_a, sack_b, sd};
      n_chk++;
      if (got !== 11'h000) begin
         n_err++;
         $display("FAIL rst_mid_abort: got %b want %b", got, 11'h000);
      end
      ereq_b = 1'b1;
      ed_b   = 7'h66;
      tick();
      want = {4'b1100, 7'h44};
      got  = {sbusy, sena, sack_a, sack_b, sd};
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL rst_mid_regrant: got %b want %b", got, want);
      end
      tick();
      want = {4'b1010, 7'h44};
      got  = {sbusy, sena, sack_a, sack_b, sd};
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL rst_mid_ack: got %b want %b", got, want);
      end
      ereq_a = 1'b0;
      ereq_b = 1'b0;
   endtask

`ifdef REG7_ARB_CLR_EN
   task automatic test_clr();
      logic [11:0] got, want;
      do_reset();
      ereq_a = 1'b1;
      ed_a   = 7'h12;
      tick();
      tick();
      ereq_a = 1'b0;
      tick();
      eclr   = 1'b1;
      ereq_a = 1'b1;
      ed_a   = 7'h55;
      tick();
      eclr = 1'b0;
      want = {1'b1, 4'b1000, 7'h12};
      got  = {sclr, sbusy, sena, sack_a, sack_b, sd};
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL clr_pulse: got %b want %b", got, want);
      end
      tick();
      want = {1'b0, 4'b0000, 7'h12};
      got  = {sclr, sbusy, sena, sack_a, sack_b, sd};
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL clr_return: got %b want %b", got, want);
      end
      tick();
      want = {1'b0, 4'b1100, 7'h55};
      got  = {sclr, sbusy, sena, sack_a, sack_b, sd};
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL clr_then_a: got %b want %b", got, want);
      end
      ereq_a = 1'b0;
      tick();
   endtask
`endif

   initial begin
      @(negedge eck);
      test_reset();
      test_single_a();
      test_dual_rr();
      test_data_hold();
      test_drop_after_grant();
      test_reset_mid();
`ifdef REG7_ARB_CLR_EN
      test_clr();
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
